// File: rtl/freq_step_sequencer_if.sv
// Tracker/PWM-facing bundle of the frequency step sequencer.
// master = sequencer side, slave = tracker/PWM side.
interface freq_step_sequencer_if #(
  parameter int PERIOD_W = 16
) ();
  logic                enable;
  logic                freq_rdy;
  logic                freq_up_down;
  logic                freq_opt;
  logic [PERIOD_W-1:0] period_out;
  logic                period_load;
  logic                tracker_nrst;
  logic                locked;
  logic                at_limit;

  modport master (
    input  enable,
    input  freq_rdy,
    input  freq_up_down,
    input  freq_opt,
    output period_out,
    output period_load,
    output tracker_nrst,
    output locked,
    output at_limit
  );

  modport slave (
    output enable,
    output freq_rdy,
    output freq_up_down,
    output freq_opt,
    input  period_out,
    input  period_load,
    input  tracker_nrst,
    input  locked,
    input  at_limit
  );
endinterface

// File: rtl/freq_step_sequencer.sv
// Switching-frequency step sequencer: step adaptation, clamping, settle blanking.
// Optional macro RELOCK_EN: timed fine re-search out of LOCKED.
module freq_step_sequencer #(
  parameter int PERIOD_W    = 16,
  parameter int PERIOD_INIT = 1250,
  parameter int PERIOD_MIN  = 1000,
  parameter int PERIOD_MAX  = 1667,
  parameter int STEP_INIT   = 32,
  parameter int STEP_MIN    = 1,
  parameter int SETTLE_CYC  = 2500,
  parameter int RELOCK_CYC  = 5000000
) (
  input  logic clk,
  input  logic nrst,
  freq_step_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    TRACK,
    LOCKED
  } state_e;

  localparam int CW = 32;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] RELOCK_LD = CW'(RELOCK_CYC - 1);
  localparam logic [PERIOD_W-1:0] PINIT = PERIOD_W'(PERIOD_INIT);
  localparam logic [PERIOD_W-1:0] PMIN  = PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W-1:0] PMAX  = PERIOD_W'(PERIOD_MAX);
  localparam logic [PERIOD_W-1:0] SINIT = PERIOD_W'(STEP_INIT);
  localparam logic [PERIOD_W-1:0] SMIN  = PERIOD_W'(STEP_MIN);
  localparam logic [PERIOD_W:0]   PMIN_X = {1'b0, PMIN};
  localparam logic [PERIOD_W:0]   PMAX_X = {1'b0, PMAX};

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] step_q, step_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dir_valid_q, dir_valid_d;
  logic                last_dir_q, last_dir_d;
  logic                at_limit_q, at_limit_d;
  logic                load_q, load_d;
  logic                trk_q, trk_d;
  logic                locked_q, locked_d;

  logic                rev;
  logic [PERIOD_W-1:0] step_half;
  logic [PERIOD_W-1:0] step_eff;
  logic [PERIOD_W:0]   stepx;
  logic [PERIOD_W:0]   perx;
  logic [PERIOD_W:0]   cand;
  logic                lo_clip;
  logic                hi_clip;
  logic [PERIOD_W-1:0] result;

  assign rev = dir_valid_q
             && (bus.freq_up_down != last_dir_q);
  assign step_half = ((step_q >> 1) < SMIN)
                   ? SMIN : (step_q >> 1);
  assign step_eff = rev ? step_half : step_q;
  assign stepx = {1'b0, step_eff};
  assign perx  = {1'b0, period_q};

  // Extra bit keeps overflow visible; underflow saturates to zero.
  always_comb begin
    cand = perx + stepx;
    if (bus.freq_up_down) begin
      cand = (stepx > perx) ? '0 : perx - stepx;
    end
  end

  assign lo_clip = cand < PMIN_X;
  assign hi_clip = cand > PMAX_X;
  assign result  = lo_clip ? PMIN
                 : hi_clip ? PMAX
                 : cand[PERIOD_W-1:0];

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    dir_valid_d = dir_valid_q;
    last_dir_d  = last_dir_q;
    at_limit_d  = at_limit_q;
    load_d      = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = SETTLE;
          period_d    = PINIT;
          step_d      = SINIT;
          dir_valid_d = 1'b0;
          at_limit_d  = 1'b0;
          load_d      = 1'b1;
          cnt_d       = SETTLE_LD;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = TRACK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        TRACK: begin
          if (bus.freq_opt) begin
            state_d = LOCKED;
            cnt_d   = RELOCK_LD;
          end else if (bus.freq_rdy) begin
            step_d      = step_eff;
            period_d    = result;
            last_dir_d  = bus.freq_up_down;
            dir_valid_d = 1'b1;
            if (lo_clip || hi_clip) begin
              at_limit_d = 1'b1;
            end
            load_d  = 1'b1;
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end
        end
        LOCKED: begin
`ifdef RELOCK_EN
          if (cnt_q == '0) begin
            step_d  = SMIN;
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    trk_d    = (state_d == TRACK);
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      period_q    <= PINIT;
      step_q      <= SINIT;
      cnt_q       <= '0;
      dir_valid_q <= 1'b0;
      last_dir_q  <= 1'b0;
      at_limit_q  <= 1'b0;
      load_q      <= 1'b0;
      trk_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      dir_valid_q <= dir_valid_d;
      last_dir_q  <= last_dir_d;
      at_limit_q  <= at_limit_d;
      load_q      <= load_d;
      trk_q       <= trk_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.period_out   = period_q;
  assign bus.period_load  = load_q;
  assign bus.tracker_nrst = trk_q;
  assign bus.locked       = locked_q;
  assign bus.at_limit     = at_limit_q;

endmodule
